// File: rtl/order_ingress_sequencer.sv
// Ingress sequencer: buffers order/max-limit messages in a FIFO and issues them one at a
// time to the risk stage, waiting for completion or a timeout between messages.
module order_ingress_sequencer #(
    parameter int AMT_W   = 32,
    parameter int CID_W   = 5,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic             msg_is_max,
    input  logic [CID_W-1:0] msg_client_id,
    input  logic [AMT_W-1:0] msg_amount,
    output logic [CID_W-1:0] client_id,
    output logic [AMT_W-1:0] amount,
    output logic             new_order,
    output logic             new_max,
    input  logic             stage_done,
    output logic             busy,
    output logic             timeout_pulse,
    output logic [CNT_W-1:0] orders_issued,
    output logic [CNT_W-1:0] maxes_issued,
    output logic [CNT_W-1:0] timeouts
);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [PW:0]   FULL_CNT  = (PW+1)'(DEPTH);
    localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

    typedef struct packed {
        logic             is_max;
        logic [CID_W-1:0] cid;
        logic [AMT_W-1:0] amt;
    } msg_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t        state;
    msg_t          mem [DEPTH];
    msg_t          head;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, count_next;
    logic [WW-1:0] wait_cnt;
    logic          push, pop;

    assign push = msg_valid && msg_ready;
    assign pop  = (state == IDLE) && (count != '0);
    assign head = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= '{is_max: msg_is_max, cid: msg_client_id, amt: msg_amount};
    end

    // Pointers are PW bits wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            msg_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count     <= count_next;
            msg_ready <= (count_next != FULL_CNT);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            client_id     <= '0;
            amount        <= '0;
            new_order     <= 1'b0;
            new_max       <= 1'b0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
            wait_cnt      <= '0;
            orders_issued <= '0;
            maxes_issued  <= '0;
            timeouts      <= '0;
        end else begin
            new_order     <= 1'b0;
            new_max       <= 1'b0;
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        client_id <= head.cid;
                        amount    <= head.amt;
                        new_order <= !head.is_max;
                        new_max   <= head.is_max;
                        if (head.is_max) maxes_issued  <= maxes_issued + 1'b1;
                        else             orders_issued <= orders_issued + 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // Completion takes priority over a coincident expiry.
                    if (stage_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_pulse <= 1'b1;
                        timeouts      <= timeouts + 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_order_ingress_sequencer.sv
// Directed bench for order_ingress_sequencer with hand-computed expectations.
module tb_order_ingress_sequencer;
    localparam int AMT_W = 32, CID_W = 5, DEPTH = 8, TIMEOUT = 64, CNT_W = 16;

    logic             clk = 1'b0, rst = 1'b1;
    logic             msg_valid = 1'b0, msg_ready, msg_is_max = 1'b0;
    logic [CID_W-1:0] msg_client_id = '0, client_id;
    logic [AMT_W-1:0] msg_amount = '0, amount;
    logic             new_order, new_max, stage_done = 1'b0, busy, timeout_pulse;
    logic [CNT_W-1:0] orders_issued, maxes_issued, timeouts;

    int checks = 0, errors = 0;
    logic [37:0] log_q[$];
    logic [37:0] exp_q[$];

    order_ingress_sequencer #(.AMT_W(AMT_W), .CID_W(CID_W), .DEPTH(DEPTH),
                              .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_is_max(msg_is_max), .msg_client_id(msg_client_id), .msg_amount(msg_amount),
        .client_id(client_id), .amount(amount), .new_order(new_order), .new_max(new_max),
        .stage_done(stage_done), .busy(busy), .timeout_pulse(timeout_pulse),
        .orders_issued(orders_issued), .maxes_issued(maxes_issued), .timeouts(timeouts));

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && (new_order || new_max))
            log_q.push_back({new_max, client_id, amount});

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        msg_valid = 1'b0;
        stage_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        log_q.delete();
        exp_q.delete();
    endtask

    // Holds the message on the bus until it is taken (bounded).
    task automatic push(input logic is_max, input logic [CID_W-1:0] cid, input logic [AMT_W-1:0] amt);
        bit acc = 0;
        msg_valid = 1'b1;
        msg_is_max = is_max;
        msg_client_id = cid;
        msg_amount = amt;
        for (int i = 0; i < 400 && !acc; i++) begin
            acc = msg_ready;
            tick();
        end
        msg_valid = 1'b0;
        if (!acc) chk("push_accept", 0, 1);
        exp_q.push_back({is_max, cid, amt});
    endtask

    task automatic wait_log(input int n, input string tag);
        int i = 0;
        while (log_q.size() < n && i < 500) begin
            tick();
            i++;
        end
        chk(tag, log_q.size(), n);
    endtask

    task automatic wait_pulse(input string tag);
        int i = 0;
        while (!(new_order || new_max) && i < 200) begin
            tick();
            i++;
        end
        chk(tag, new_order || new_max, 1);
    endtask

    initial begin
        int bad;
        do_reset();
        // 1: reset state, basic latency
        chk("rst_ready", msg_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {new_order, new_max, timeout_pulse, client_id, amount}, 0);
        chk("rst_cnts", {orders_issued, maxes_issued, timeouts}, 0);
        push(0, 5'd3, 32'd100);
        chk("t1_n1_order", new_order, 0);
        tick();
        chk("t1_order", new_order, 1);
        chk("t1_cid", client_id, 3);
        chk("t1_amt", amount, 100);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_single", new_order, 0);
        stage_done = 1'b1;
        tick();
        stage_done = 1'b0;
        chk("t1_idle", busy, 0);
        chk("t1_orders", orders_issued, 1);
        chk("t1_hold_amt", amount, 100);

        // 2: fill to full, producer held off, drain in order
        do_reset();
        for (int i = 0; i < 9; i++) push(0, 5'(i), 32'(200 + i));
        chk("t2_full", msg_ready, 0);
        chk("t2_one_issued", orders_issued, 1);
        stage_done = 1'b1;
        push(1, 5'd9, 32'd209);
        wait_log(10, "t2_count");
        for (int i = 0; i < 10 && i < log_q.size(); i++)
            chk($sformatf("t2_order%0d", i), log_q[i], exp_q[i]);
        stage_done = 1'b0;
        chk("t2_no_to", timeouts, 0);

        // 3: timeout on an unanswered max update
        do_reset();
        push(1, 5'd7, 32'd5000);
        push(0, 5'd1, 32'd11);
        wait_pulse("t3_max_seen");
        chk("t3_is_max", new_max, 1);
        repeat (TIMEOUT) tick();
        chk("t3_early", timeout_pulse, 0);
        tick();
        chk("t3_to", timeout_pulse, 1);
        chk("t3_tocnt", timeouts, 1);
        chk("t3_maxcnt", maxes_issued, 1);
        tick();
        chk("t3_to_once", timeout_pulse, 0);
        chk("t3_next", {new_order, client_id, amount}, {1'b1, 5'd1, 32'd11});
        tick();
        stage_done = 1'b1;
        tick();
        stage_done = 1'b0;

        // 4: completion coincident with expiry wins
        do_reset();
        push(0, 5'd2, 32'd22);
        wait_pulse("t4_seen");
        repeat (TIMEOUT) tick();
        stage_done = 1'b1;
        tick();
        stage_done = 1'b0;
        chk("t4_no_pulse", timeout_pulse, 0);
        chk("t4_tocnt", timeouts, 0);
        chk("t4_idle", busy, 0);

        // 5: continuous stream across pointer wrap with concurrent push/pop
        do_reset();
        stage_done = 1'b1;
        for (int i = 0; i < 24; i++) push(1'(i % 3 == 0), 5'(i + 4), 32'(1000 + 7 * i));
        wait_log(24, "t5_count");
        bad = 0;
        for (int i = 0; i < 24 && i < log_q.size(); i++)
            if (log_q[i] !== exp_q[i]) bad++;
        chk("t5_wrap_order", bad, 0);
        chk("t5_orders", orders_issued, 16);
        chk("t5_maxes", maxes_issued, 8);
        stage_done = 1'b0;
        tick();

        // 6: async reset while waiting with messages queued
        do_reset();
        for (int i = 0; i < 4; i++) push(0, 5'(20 + i), 32'(300 + i));
        tick();
        chk("t6_busy_pre", busy, 1);
        rst = 1'b1;
        #1;
        chk("t6_outs", {busy, new_order, new_max, timeout_pulse, client_id, amount}, 0);
        chk("t6_cnts", {orders_issued, maxes_issued, timeouts}, 0);
        chk("t6_ready", msg_ready, 1);
        tick();
        rst = 1'b0;
        log_q.delete();
        repeat (6) tick();
        chk("t6_no_pulse", log_q.size(), 0);
        chk("t6_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
